serial_shift_right_unit: RTL and testbench

Multi-cycle right shifter for the execute stage. It performs SRL/SRLI and SRA/SRAI one bit position per clock, and is the right-direction counterpart of the existing fixed 1-bit left shifter used in branch-offset generation. The hazard unit stalls the pipeline while busy is high and captures the result when done pulses. A flush input aborts an in-flight operation on a pipeline flush.

---
 rtl/serial_shift_right_unit.sv | 65 ++++++
 tb/tb_serial_shift_right_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/serial_shift_right_unit.sv
// Multi-cycle SRL/SRA unit: shifts the working register right one bit per clock.
// The fill bit is frozen at start so arithmetic shifts sign-extend for any amount.
module serial_shift_right_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               arith,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               flush,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]         state;
    logic [SHAMT_W-1:0] count;
    logic               fill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            result <= '0;
            count  <= '0;
            fill   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // flush has priority over a coincident start
                    if (start && !flush) begin
                        result <= operand;
                        count  <= shamt;
                        fill   <= arith & operand[WIDTH-1];
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (count == '0) begin
                        state <= DONE;
                    end else begin
                        result <= {fill, result[WIDTH-1:1]};
                        count  <= count - SHAMT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign busy  = (state == SHIFT) || (state == DONE);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_serial_shift_right_unit.sv
// Directed and randomised bench for serial_shift_right_unit with a result/latency scoreboard.
module tb_serial_shift_right_unit;

    logic        clk = 1'b0;
    logic        rst, start, arith, flush;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic        ready, busy, done;
    logic [31:0] result;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] lat;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int fails  = 0;

    serial_shift_right_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .arith(arith), .operand(operand),
        .shamt(shamt), .flush(flush), .ready(ready), .busy(busy), .done(done),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE; optionally pulse a competing start at edge E3.
    task automatic run_op(input logic [31:0] op, input logic [4:0] sh, input logic ar,
                          input logic intrude);
        exp_t e;
        logic signed [31:0] s;
        int n;
        s = op;
        if (ar) e.res = s >>> sh;
        else    e.res = op >> sh;
        e.lat = 32'(sh) + 32'd1;
        sb.push_back(e);
        operand = op; shamt = sh; arith = ar; start = 1'b1;
        step();
        start = 1'b0; operand = ~op; shamt = ~sh; arith = ~ar;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("ready_after_start", {31'd0, ready}, 32'd0);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            if (intrude) begin
                start   = (n == 2);
                operand = 32'h1234_5678;
                shamt   = 5'd1;
            end
            step();
            n++;
            if (done !== 1'b1) chk("busy_while_shifting", {31'd0, busy}, 32'd1);
        end
        start = 1'b0;
        e = sb.pop_front();
        chk("done_latency", 32'(n), e.lat);
        chk("result", result, e.res);
        step();
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("ready_after_done", {31'd0, ready}, 32'd1);
        chk("result_held", result, e.res);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; arith = 1'b0; flush = 1'b0;
        operand = '0; shamt = '0;
        #1 rst = 1'b1;
        #1;
        chk("reset_ready", {31'd0, ready}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        #10 rst = 1'b0;
        step();

        // Sign fill, zero fill, positive operand under SRA
        run_op(32'hF000_0000, 5'd4, 1'b1, 1'b0);
        run_op(32'hF000_0000, 5'd4, 1'b0, 1'b0);
        run_op(32'h7000_0000, 5'd4, 1'b1, 1'b0);
        // Shift amount extremes
        run_op(32'h8000_0001, 5'd0, 1'b1, 1'b0);
        run_op(32'h8000_0000, 5'd31, 1'b1, 1'b0);
        run_op(32'h8000_0000, 5'd31, 1'b0, 1'b0);
        // Start while busy is ignored
        run_op(32'hA5A5_0F0F, 5'd10, 1'b1, 1'b1);

        // Flush at E5 of a shamt=10 op
        operand = 32'hCAFE_BABE; shamt = 5'd10; arith = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_ready", {31'd0, ready}, 32'd1);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_no_done", {31'd0, done}, 32'd0);
        step();
        chk("flush_no_done_later", {31'd0, done}, 32'd0);

        // Flush and start together in IDLE: start dropped
        start = 1'b1; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        chk("flush_start_ready", {31'd0, ready}, 32'd1);
        chk("flush_start_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset in cycle 3 of a shamt=20 op
        operand = 32'hDEAD_BEEF; shamt = 5'd20; arith = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_done", {31'd0, done}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_ready", {31'd0, ready}, 32'd1);
        chk("async_rst_result", result, 32'd0);
        #2 rst = 1'b0;
        step();
        chk("post_rst_no_done", {31'd0, done}, 32'd0);
        run_op(32'h8765_4321, 5'd7, 1'b1, 1'b0);

        // Random back-to-back ops, each started on the first ready cycle
        for (int i = 0; i < 1000; i++) begin
            run_op($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0);
        end

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
